// File: rtl/memory_bist.sv
// rtl/memory_bist.sv - March-style BIST sequencer in front of a 16x4 synchronous RAM
// Host accesses pass through when idle; a start runs write/read true and inverted phases.
module memory_bist #(
  parameter logic [3:0] PATTERN_XOR = 4'h0
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Start,
  input  logic       i_HostWriteEnable,
  input  logic [3:0] i_HostAddress,
  input  logic [3:0] i_HostData,
  output logic       o_RamWriteEnable,
  output logic [3:0] o_RamAddress,
  output logic [3:0] o_RamData,
  input  logic [3:0] i_RamReadData,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Pass,
  output logic [5:0] o_ErrorCount,
  output logic [3:0] o_FirstFailAddr,
  output logic       o_FirstFailPhase
);

  typedef enum logic [2:0] {
    IDLE,
    WR_TRUE,
    RD_TRUE,
    WR_INV,
    RD_INV,
    FLUSH
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] addr;
  logic [3:0] true_word;
  logic       last_addr;
  logic       start_accept;

  logic       cmp_valid;
  logic [3:0] cmp_expected;
  logic [3:0] cmp_addr;
  logic       cmp_phase;
  logic       mismatch;
  logic [5:0] error_count_next;

  assign true_word        = addr ^ PATTERN_XOR;
  assign last_addr        = (addr == 4'hF);
  assign start_accept     = (state == IDLE) && i_Start;
  assign o_Busy           = (state != IDLE);
  assign mismatch         = cmp_valid && (i_RamReadData != cmp_expected);
  assign error_count_next = o_ErrorCount + {5'd0, mismatch};

  always_comb begin
    state_next       = state;
    o_RamWriteEnable = 1'b0;
    o_RamAddress     = addr;
    o_RamData        = 4'h0;
    case (state)
      IDLE: begin
        o_RamWriteEnable = i_HostWriteEnable;
        o_RamAddress     = i_HostAddress;
        o_RamData        = i_HostData;
        if (i_Start) state_next = WR_TRUE;
      end
      WR_TRUE: begin
        o_RamWriteEnable = 1'b1;
        o_RamData        = true_word;
        if (last_addr) state_next = RD_TRUE;
      end
      RD_TRUE: begin
        if (last_addr) state_next = WR_INV;
      end
      WR_INV: begin
        o_RamWriteEnable = 1'b1;
        o_RamData        = ~true_word;
        if (last_addr) state_next = RD_INV;
      end
      RD_INV: begin
        if (last_addr) state_next = FLUSH;
      end
      FLUSH: begin
        o_RamAddress = 4'h0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address wraps 15->0 on the same edge that advances the phase.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= IDLE;
      addr  <= 4'h0;
    end else begin
      state <= state_next;
      if (state == IDLE || state == FLUSH) addr <= 4'h0;
      else                                 addr <= addr + 4'h1;
    end
  end

  // Compare stage lines up expected data with the RAM's one-cycle read latency.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cmp_valid    <= 1'b0;
      cmp_expected <= 4'h0;
      cmp_addr     <= 4'h0;
      cmp_phase    <= 1'b0;
    end else begin
      cmp_valid    <= (state == RD_TRUE) || (state == RD_INV);
      cmp_expected <= (state == RD_INV) ? ~true_word : true_word;
      cmp_addr     <= addr;
      cmp_phase    <= (state == RD_INV);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Done           <= 1'b0;
      o_Pass           <= 1'b0;
      o_ErrorCount     <= 6'd0;
      o_FirstFailAddr  <= 4'h0;
      o_FirstFailPhase <= 1'b0;
    end else if (start_accept) begin
      o_Done           <= 1'b0;
      o_Pass           <= 1'b0;
      o_ErrorCount     <= 6'd0;
      o_FirstFailAddr  <= 4'h0;
      o_FirstFailPhase <= 1'b0;
    end else begin
      if (mismatch) begin
        o_ErrorCount <= error_count_next;
        if (o_ErrorCount == 6'd0) begin
          o_FirstFailAddr  <= cmp_addr;
          o_FirstFailPhase <= cmp_phase;
        end
      end
      // FLUSH holds the last compare, so pass must include it.
      if (state == FLUSH) begin
        o_Done <= 1'b1;
        o_Pass <= (error_count_next == 6'd0);
      end
    end
  end

endmodule

// File: tb/tb_memory_bist.sv
// tb/tb_memory_bist.sv - Scoreboard bench for memory_bist with behavioural faulty RAMs
// Two instances: PATTERN_XOR 0 and 4'hF, each with its own RAM model and fault masks.
module tb_memory_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic       host_we;
  logic [3:0] host_addr, host_data;

  logic       we0, we1;
  logic [3:0] ra0, ra1, wd0, wd1, rd0, rd1;
  logic       busy0, busy1, done0, done1, pass0, pass1, ffp0, ffp1;
  logic [5:0] err0, err1;
  logic [3:0] ffa0, ffa1;

  memory_bist #(.PATTERN_XOR(4'h0)) dut0 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start0),
    .i_HostWriteEnable(host_we), .i_HostAddress(host_addr), .i_HostData(host_data),
    .o_RamWriteEnable(we0), .o_RamAddress(ra0), .o_RamData(wd0), .i_RamReadData(rd0),
    .o_Busy(busy0), .o_Done(done0), .o_Pass(pass0), .o_ErrorCount(err0),
    .o_FirstFailAddr(ffa0), .o_FirstFailPhase(ffp0)
  );

  memory_bist #(.PATTERN_XOR(4'hF)) dut1 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start1),
    .i_HostWriteEnable(host_we), .i_HostAddress(host_addr), .i_HostData(host_data),
    .o_RamWriteEnable(we1), .o_RamAddress(ra1), .o_RamData(wd1), .i_RamReadData(rd1),
    .o_Busy(busy1), .o_Done(done1), .o_Pass(pass1), .o_ErrorCount(err1),
    .o_FirstFailAddr(ffa1), .o_FirstFailPhase(ffp1)
  );

  logic [3:0] mem0 [16];
  logic [3:0] mem1 [16];
  logic [3:0] f0_sa0 [16];
  logic [3:0] f0_sa1 [16];
  logic [3:0] f1_sa0 [16];
  logic [3:0] f1_sa1 [16];

  // Registered read returns the old word when reading during a write.
  always @(posedge clk) begin
    rd0 <= (mem0[ra0] & ~f0_sa0[ra0]) | f0_sa1[ra0];
    rd1 <= (mem1[ra1] & ~f1_sa0[ra1]) | f1_sa1[ra1];
    if (we0) mem0[ra0] <= wd0;
    if (we1) mem1[ra1] <= wd1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int err;
    int addr;
    int phase;
    int pass;
    int busy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [3:0] trace[$];
  logic trace_en = 1'b0;

  task automatic push_exp(input int dut, input int err, input int addr, input int phase, input int pass);
    exp_t e;
    e.err = err; e.addr = addr; e.phase = phase; e.pass = pass; e.busy = 65;
    if (dut == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  int bcnt0 = 0;
  int bcnt1 = 0;
  logic pd0 = 1'b0;
  logic pd1 = 1'b0;

  // Monitor: on each rising o_Done pop the oldest expectation and compare.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      bcnt0 = 0;
      bcnt1 = 0;
    end else begin
      if (busy0) bcnt0++;
      if (busy1) bcnt1++;
    end
    if (trace_en && busy0 && we0 && ra0 == 4'd5) trace.push_back(wd0);
    if (done0 && !pd0) begin
      if (q0.size() == 0) check("dut0 unexpected done", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("dut0 err_count", int'(err0), e0.err);
        check("dut0 first_addr", int'(ffa0), e0.addr);
        check("dut0 first_phase", int'(ffp0), e0.phase);
        check("dut0 pass", int'(pass0), e0.pass);
        check("dut0 busy_cycles", bcnt0, e0.busy);
      end
      bcnt0 = 0;
    end
    if (done1 && !pd1) begin
      if (q1.size() == 0) check("dut1 unexpected done", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("dut1 err_count", int'(err1), e1.err);
        check("dut1 first_addr", int'(ffa1), e1.addr);
        check("dut1 first_phase", int'(ffp1), e1.phase);
        check("dut1 pass", int'(pass1), e1.pass);
        check("dut1 busy_cycles", bcnt1, e1.busy);
      end
      bcnt1 = 0;
    end
    pd0 = done0;
    pd1 = done1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 16; i++) begin
      f0_sa0[i] = 4'h0; f0_sa1[i] = 4'h0;
      f1_sa0[i] = 4'h0; f1_sa1[i] = 4'h0;
    end
  endtask

  task automatic pulse_start();
    start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy0 || busy1) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, " completes"}, int'(k < 300), 1);
  endtask

  task automatic run_test(input string name);
    pulse_start();
    wait_idle(name);
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    host_we = 1'b1; host_addr = 4'h3; host_data = 4'h6;
    clear_faults();
    #12;
    check("reset busy", int'(busy0), 0);
    check("reset done", int'(done0), 0);
    check("reset pass", int'(pass0), 0);
    check("reset err", int'(err0), 0);
    check("reset ffa", int'(ffa0), 0);
    check("reset ffp", int'(ffp0), 0);
    check("reset ram we", int'(we0), 1);
    check("reset ram addr", int'(ra0), 3);
    check("reset ram data", int'(wd0), 6);
    check("reset busy dut1", int'(busy1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    host_we = 1'b0;
    tick(2);

    trace_en = 1'b1;
    push_exp(0, 0, 0, 0, 1);
    push_exp(1, 0, 0, 0, 1);
    run_test("fault free");
    trace_en = 1'b0;
    check("trace length", trace.size(), 2);
    if (trace.size() == 2) begin
      check("trace true word", int'(trace[0]), 5);
      check("trace inv word", int'(trace[1]), 10);
    end

    f0_sa0[5] = 4'b0100;
    push_exp(0, 1, 5, 0, 0);
    push_exp(1, 0, 0, 0, 1);
    run_test("addr5 bit2 sa0");
    clear_faults();

    for (int i = 0; i < 16; i++) f0_sa1[i] = 4'b0001;
    push_exp(0, 16, 0, 0, 0);
    push_exp(1, 0, 0, 0, 1);
    run_test("bit0 sa1");
    clear_faults();

    f1_sa0[15] = 4'b1000;
    push_exp(0, 0, 0, 0, 1);
    push_exp(1, 1, 15, 1, 0);
    run_test("flush compare");
    clear_faults();

    host_we = 1'b1; host_addr = 4'h3; host_data = 4'hA;
    @(negedge clk);
    host_we = 1'b0; host_data = 4'h0;
    @(negedge clk);
    check("passthrough read dut0", int'(rd0), 10);
    check("passthrough read dut1", int'(rd1), 10);

    push_exp(0, 0, 0, 0, 1);
    push_exp(1, 0, 0, 0, 1);
    pulse_start();
    tick(18);
    start0 = 1'b1; start1 = 1'b1;
    host_we = 1'b1; host_addr = 4'h7; host_data = 4'h9;
    #1;
    check("busy ignores host we", int'(we0), 0);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    host_we = 1'b0;
    wait_idle("restart ignored");
    tick(2);

    for (int i = 0; i < 16; i++) f0_sa1[i] = 4'b0001;
    pulse_start();
    tick(29);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy0), 0);
    check("abort err", int'(err0), 0);
    check("abort done", int'(done0), 0);
    check("abort pass", int'(pass0), 0);
    check("abort ffa", int'(ffa0), 0);
    check("abort busy dut1", int'(busy1), 0);
    check("abort ram addr", int'(ra0), int'(host_addr));
    @(negedge clk);
    rst_n = 1'b1;
    clear_faults();
    tick(2);
    push_exp(0, 0, 0, 0, 1);
    push_exp(1, 0, 0, 0, 1);
    run_test("after abort");

    push_exp(0, 0, 0, 0, 1);
    push_exp(1, 0, 0, 0, 1);
    push_exp(0, 0, 0, 0, 1);
    push_exp(1, 0, 0, 0, 1);
    start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    wait_idle("held start first");
    check("held done high", int'(done0), 1);
    @(negedge clk);
    check("held done one cycle", int'(done0), 0);
    check("held restarted", int'(busy0), 1);
    start0 = 1'b0; start1 = 1'b0;
    wait_idle("held start second");
    tick(2);

    check("dut0 queue drained", q0.size(), 0);
    check("dut1 queue drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
